// File: rtl/calc_instr_sequencer_if.sv
// Instruction push channel into the calculator sequencer (valid/ready, one packed word per beat).
interface calc_instr_sequencer_if #(
  parameter int IW = 23
);
  logic          In_valid;
  logic          In_ready;
  logic [IW-1:0] In_instr;

  modport master (output In_valid, output In_instr, input In_ready);
  modport slave  (input In_valid, input In_instr, output In_ready);
endinterface

// File: rtl/calc_instr_sequencer.sv
// Buffers packed calculator instructions in a FIFO, issues one per cycle, captures busY/Carry one cycle later.
// Build option: define CALC_SEQ_STATS_EN to add the Issue_cnt/Carry_cnt statistics outputs.
//
// state | meaning
// IDLE  | FIFO empty, nothing to issue
// RUN   | popping one entry per edge
// PAUSE | Pause held, entries wait in the FIFO
module calc_instr_sequencer #(
  parameter int DEPTH = 4,
  parameter int IW    = 23
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  calc_instr_sequencer_if.slave in_if,
  input  logic                  Pause,
  output logic                  WEN,
  output logic [2:0]            RW,
  output logic [2:0]            RX,
  output logic [2:0]            RY,
  output logic [7:0]            DataIn,
  output logic                  Sel,
  output logic [3:0]            Ctrl,
  input  logic [7:0]            busY,
  input  logic                  Carry,
  output logic                  Res_valid,
  output logic [7:0]            Res_y,
  output logic                  Res_carry,
  output logic                  Busy
`ifdef CALC_SEQ_STATS_EN
  ,
  output logic [15:0]           Issue_cnt,
  output logic [15:0]           Carry_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, full, empty;
  logic          issued_q;
  logic [IW-1:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // Ready is forced low while reset is held, so no word can slip in during reset.
  assign in_if.In_ready = Rst_n & ~full;
  assign push  = in_if.In_valid & in_if.In_ready;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.In_instr;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = !Pause;
          state_d = Pause ? PAUSE : RUN;
        end
      end
      RUN: begin
        if (Pause) begin
          state_d = PAUSE;
        end else if (!empty) begin
          pop = 1'b1;
          if (count_q == CW'(1) && !push) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      PAUSE: begin
        if (!Pause) begin
          if (empty) begin
            state_d = IDLE;
          end else begin
            pop     = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue registers: fields hold between pops, only WEN drops so the RF is never rewritten.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WEN      <= 1'b0;
      RW       <= '0;
      RX       <= '0;
      RY       <= '0;
      DataIn   <= '0;
      Sel      <= 1'b0;
      Ctrl     <= '0;
      issued_q <= 1'b0;
    end else begin
      issued_q <= pop;
      if (pop) begin
        Ctrl   <= head[22:19];
        Sel    <= head[18];
        WEN    <= head[17];
        RW     <= head[16:14];
        RX     <= head[13:11];
        RY     <= head[10:8];
        DataIn <= head[7:0];
      end else begin
        WEN    <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Res_valid <= 1'b0;
      Res_y     <= '0;
      Res_carry <= 1'b0;
    end else begin
      Res_valid <= issued_q;
      if (issued_q) begin
        Res_y     <= busY;
        Res_carry <= Carry;
      end
    end
  end

  assign Busy = !empty | issued_q | WEN;

`ifdef CALC_SEQ_STATS_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Issue_cnt <= '0;
      Carry_cnt <= '0;
    end else begin
      if (pop)              Issue_cnt <= Issue_cnt + 16'd1;
      if (issued_q && Carry) Carry_cnt <= Carry_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_instr_sequencer.sv
// Bench for calc_instr_sequencer: small calculator environment, queue-level reference model,
// per-cycle compare process, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_calc_instr_sequencer;
  localparam int DEPTH = 4;
  typedef logic [22:0] word_t;

  logic       Clk   = 1'b0;
  logic       Rst_n = 1'b1;
  logic       Pause = 1'b0;
  logic       WEN, Sel, Carry, Res_valid, Res_carry, Busy;
  logic [2:0] RW, RX, RY;
  logic [7:0] DataIn, busY, Res_y;
  logic [3:0] Ctrl;
`ifdef CALC_SEQ_STATS_EN
  logic [15:0] Issue_cnt, Carry_cnt;
`endif

  calc_instr_sequencer_if #(.IW(23)) in_if ();

  calc_instr_sequencer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .in_if(in_if), .Pause(Pause),
    .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl),
    .busY(busY), .Carry(Carry),
    .Res_valid(Res_valid), .Res_y(Res_y), .Res_carry(Res_carry), .Busy(Busy)
`ifdef CALC_SEQ_STATS_EN
    , .Issue_cnt(Issue_cnt), .Carry_cnt(Carry_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // ALU of the bench calculator; op 0 is add with carry out.
  function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      4'd0:    alu = {1'b0, x} + {1'b0, y};
      4'd1:    alu = {1'b0, x} - {1'b0, y};
      4'd2:    alu = {1'b0, x & y};
      4'd3:    alu = {1'b0, x | y};
      4'd4:    alu = {1'b0, x ^ y};
      default: alu = {1'b0, x};
    endcase
  endfunction

  // Calculator environment driven by the DUT outputs.
  logic [7:0] rf [8] = '{default: 8'h00};
  logic [8:0] calc_alu;
  assign busY     = rf[RY];
  assign calc_alu = alu(Ctrl, rf[RX], rf[RY]);
  assign Carry    = calc_alu[8];
  always @(posedge Clk) if (WEN) rf[RW] <= Sel ? calc_alu[7:0] : DataIn;

  // Reference model: queue of accepted words, own copy of the register file.
  word_t       mq [$];
  logic [7:0]  mrf [8] = '{default: 8'h00};
  logic        e_wen, e_sel, e_rv, e_rc;
  logic [2:0]  e_rw, e_rx, e_ry;
  logic [7:0]  e_din, e_resy;
  logic [3:0]  e_ctrl;
  bit          m_prev;
  word_t       m_prev_w;
  int unsigned m_issues, m_carries;

  task automatic model_reset();
    mq.delete();
    {e_wen, e_sel, e_rv, e_rc, e_rw, e_rx, e_ry, e_din, e_resy, e_ctrl} = '0;
    m_prev = 0; m_prev_w = '0; m_issues = 0; m_carries = 0;
  endtask

  task automatic model_step();
    logic [8:0] r;
    word_t      w;
    bit         acc;
    acc = (in_if.In_valid === 1'b1) && (mq.size() < DEPTH);
    if (m_prev) begin
      r      = alu(m_prev_w[22:19], mrf[m_prev_w[13:11]], mrf[m_prev_w[10:8]]);
      e_rv   = 1'b1;
      e_resy = mrf[m_prev_w[10:8]];
      e_rc   = r[8];
      if (r[8]) m_carries++;
      if (m_prev_w[17]) mrf[m_prev_w[16:14]] = m_prev_w[18] ? r[7:0] : m_prev_w[7:0];
    end else begin
      e_rv = 1'b0;
    end
    if (mq.size() > 0 && Pause == 1'b0) begin
      w = mq.pop_front();
      m_prev = 1; m_prev_w = w; m_issues++;
      {e_ctrl, e_sel, e_wen, e_rw, e_rx, e_ry, e_din} = w;
    end else begin
      m_prev = 0;
      e_wen  = 1'b0;
    end
    if (acc) mq.push_back(in_if.In_instr);
  endtask

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) model_reset();
    else        model_step();
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_if.In_ready), 32'(Rst_n && (mq.size() < DEPTH)));
      chk("busy", 32'(Busy), 32'((mq.size() > 0) || m_prev));
      chk("wen", 32'(WEN), 32'(e_wen));
      chk("fields", 32'({Ctrl, Sel, RW, RX, RY, DataIn}), 32'({e_ctrl, e_sel, e_rw, e_rx, e_ry, e_din}));
      chk("res_valid", 32'(Res_valid), 32'(e_rv));
      chk("res_data", 32'({Res_y, Res_carry}), 32'({e_resy, e_rc}));
`ifdef CALC_SEQ_STATS_EN
      chk("issue_cnt", 32'(Issue_cnt), 32'(m_issues[15:0]));
      chk("carry_cnt", 32'(Carry_cnt), 32'(m_carries[15:0]));
`endif
    end
  end

  function automatic word_t mk(input logic [3:0] c, input logic s, input logic w,
                               input logic [2:0] rw, input logic [2:0] rx, input logic [2:0] ry,
                               input logic [7:0] d);
    return {c, s, w, rw, rx, ry, d};
  endfunction

  task automatic cyc(input logic v, input word_t w, input logic p);
    in_if.In_valid = v;
    in_if.In_instr = w;
    Pause          = p;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic v, p;
    in_if.In_valid = 1'b0;
    in_if.In_instr = '0;
    #1 Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk_en = 1;
    chk("rst_ready", 32'(in_if.In_ready), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_wen", 32'(WEN), 32'd0);
    chk("rst_res", 32'({Res_valid, Res_y, Res_carry}), 32'd0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    #1 chk("rel_ready", 32'(in_if.In_ready), 32'd1);
    @(negedge Clk);

    // Load r1=5, then read r1 back.
    cyc(1'b1, mk(4'd0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 8'h05), 1'b0);
    cyc(1'b1, mk(4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 8'h00), 1'b0);
    chk("ld_wen", 32'(WEN), 32'd1);
    chk("ld_rw", 32'(RW), 32'd1);
    chk("ld_data", 32'(DataIn), 32'h05);
    cyc(1'b0, '0, 1'b0);
    chk("ld_res1", 32'(Res_valid), 32'd1);
    chk("rd_wen", 32'(WEN), 32'd0);
    cyc(1'b0, '0, 1'b0);
    chk("rd_res2", 32'(Res_valid), 32'd1);
    chk("rd_y", 32'(Res_y), 32'h05);
    idle(2);

    // r1=7F, r2=01, r3=r1+r2, read r3.
    cyc(1'b1, mk(4'd0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 8'h7F), 1'b0);
    cyc(1'b1, mk(4'd0, 1'b0, 1'b1, 3'd2, 3'd0, 3'd0, 8'h01), 1'b0);
    cyc(1'b1, mk(4'd0, 1'b1, 1'b1, 3'd3, 3'd1, 3'd2, 8'h00), 1'b0);
    cyc(1'b1, mk(4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd3, 8'h00), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("add_valid", 32'(Res_valid), 32'd1);
    chk("add_carry", 32'(Res_carry), 32'd0);
    chk("add_y", 32'(Res_y), 32'h01);
    cyc(1'b0, '0, 1'b0);
    chk("sum_y", 32'(Res_y), 32'h80);
    idle(3);

    // Fill the FIFO under Pause, fifth word refused, then drain in order.
    for (int i = 0; i < 4; i++) cyc(1'b1, mk(4'd2, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 8'hA1 + 8'(i)), 1'b1);
    chk("full_ready", 32'(in_if.In_ready), 32'd0);
    cyc(1'b1, mk(4'd2, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 8'hA5), 1'b1);
    chk("full_nowen", 32'(WEN), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0);
      chk("drain_order", 32'(DataIn), 32'(8'hA1 + 8'(i)));
    end
    cyc(1'b0, '0, 1'b0);
    chk("drain_busy", 32'(Busy), 32'd0);
    chk("drain_ready", 32'(in_if.In_ready), 32'd1);
    idle(2);

    // Pause after the first pop, resume with the second word.
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(4'd1, 1'b0, 1'b1, 3'd5, 3'd0, 3'd0, 8'hB1 + 8'(i)), 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("pm_first", 32'(DataIn), 32'hB1);
    cyc(1'b0, '0, 1'b1);
    chk("pm_wen0", 32'(WEN), 32'd0);
    chk("pm_busy", 32'(Busy), 32'd1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("pm_second", 32'(DataIn), 32'hB2);
    chk("pm_wen1", 32'(WEN), 32'd1);
    idle(4);

    // Reset while the second of three words is issued.
    cyc(1'b1, mk(4'd0, 1'b0, 1'b1, 3'd6, 3'd0, 3'd0, 8'hC1), 1'b0);
    cyc(1'b1, mk(4'd0, 1'b0, 1'b1, 3'd6, 3'd0, 3'd0, 8'hC2), 1'b0);
    cyc(1'b1, mk(4'd0, 1'b0, 1'b1, 3'd6, 3'd0, 3'd0, 8'hC3), 1'b0);
    chk("mr_issue2", 32'(DataIn), 32'hC2);
    in_if.In_valid = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("mr_out0", 32'({WEN, RW, RX, RY, DataIn, Sel, Ctrl}), 32'd0);
    chk("mr_res0", 32'({Res_valid, Res_y, Res_carry}), 32'd0);
    chk("mr_ready0", 32'(in_if.In_ready), 32'd0);
    chk("mr_busy0", 32'(Busy), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0);
      chk("mr_noissue", 32'({WEN, Res_valid}), 32'd0);
    end
    chk("mr_idle_busy", 32'(Busy), 32'd0);

    // Random traffic with bursts of Pause.
    p = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 12) p = ~p;
      cyc(v, word_t'($urandom), p);
    end
    idle(8);
    chk("end_busy", 32'(Busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
